// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, controller states and byte-mask helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        return size == SZ_B ? MASK_B : size == SZ_H ? MASK_H : size == SZ_W ? MASK_W : MASK_D;
    endfunction

    // An access is aligned when the low log2(bytes) address bits are all zero.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        return |(off & 3'((4'd1 << size) - 4'd1));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: execute request, writeback response and data-memory port of the load/store unit.
interface lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic        in_wen;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_misalign;
    logic [63:0] mem_addr;
    logic        mem_ce;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    modport slave (
        input  in_valid, in_addr, in_wen, in_size, in_unsigned, in_wdata, in_rd, out_ready, mem_rdata,
        output in_ready, out_valid, out_rdata, out_rd, out_misalign,
               mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
    );

    modport master (
        output in_valid, in_addr, in_wen, in_size, in_unsigned, in_wdata, in_rd, out_ready, mem_rdata,
        input  in_ready, out_valid, out_rdata, out_rd, out_misalign,
               mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: selects the addressed lanes of a memory doubleword and sign/zero-extends them.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [63:0] data_o
);
    logic [63:0] sh;

    assign sh = rdata_i >> {off_i, 3'b000};

    always_comb
        data_o = size_i == SZ_B ? {{56{~uns_i & sh[7]}}, sh[7:0]} :
                 size_i == SZ_H ? {{48{~uns_i & sh[15]}}, sh[15:0]} :
                 size_i == SZ_W ? {{32{~uns_i & sh[31]}}, sh[31:0]} : sh;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: accepts one memory op, drives the combinational data memory for a single cycle
// and presents the extended load result (or a misalignment flag) to writeback.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit ALIGN_ADDR     = 1'b1,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input logic   clk,
    input logic   reset_n,
    lsu_if.slave  bus
);
    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [63:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic [63:0] ext;
    logic        acc;
    logic        acs;

    lsu_load_ext u_ext (
        .rdata_i (bus.mem_rdata),
        .off_i   (addr_q[2:0]),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .data_o  (ext)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    assign acc = bus.in_valid && bus.in_ready;
    assign acs = state_q == ACCESS;

    // A new accept in RESP coincides with the handoff, so it overrides the return to IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        if (acs) begin
            state_d = RESP;
            rdata_d = wen_q ? '0 : ext;
        end else if (state_q == RESP && bus.out_ready) begin
            state_d = IDLE;
        end
        if (acc) begin
            addr_d  = bus.in_addr;
            wen_d   = bus.in_wen;
            size_d  = bus.in_size;
            uns_d   = bus.in_unsigned;
            wdata_d = bus.in_wdata;
            rd_d    = bus.in_rd;
            rdata_d = '0;
            mis_d   = MISALIGN_CHECK && misaligned(bus.in_addr[2:0], bus.in_size);
            state_d = mis_d ? RESP : ACCESS;
        end
    end

    assign bus.in_ready     = reset_n && (state_q == IDLE || (state_q == RESP && bus.out_ready));
    assign bus.out_valid    = state_q == RESP;
    assign bus.out_rdata    = rdata_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_misalign = mis_q;

    assign bus.mem_ce    = acs;
    assign bus.mem_we    = acs && wen_q;
    assign bus.mem_addr  = acs ? (ALIGN_ADDR ? {addr_q[63:3], 3'b000} : addr_q) : '0;
    assign bus.mem_wdata = acs ? wdata_q << {addr_q[2:0], 3'b000} : '0;
    assign bus.mem_wmask = (acs && wen_q) ? 8'(size_mask(size_q) << addr_q[2:0]) : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a byte-level reference model of the memory path.
module tb_lsu_ctrl;
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] mem_word = '0;
    logic [63:0] stage_word = '0;
    logic [63:0] p_addr = '0;
    logic [63:0] p_wdata = '0;
    logic [7:0]  p_mask = '0;
    logic        p_we = 1'b0;
    logic        took = 1'b0;
    int          nvec = 0;
    int          nerr = 0;
    int          ce_cnt = 0;
    exp_t        sb[$];

    lsu_if bus ();

    lsu_ctrl #(.ALIGN_ADDR(1'b1), .MISALIGN_CHECK(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = bus.mem_ce ? mem_word : '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ld_model(input logic [63:0] w, input logic [2:0] off,
                                             input logic [1:0] sz, input logic uns);
        int n = 1 << sz;
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 8) r[8*i +: 8] = w[8*(int'(off) + i) +: 8];
        if (!uns && n < 8 && r[8*n-1])
            for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [63:0] wd_model(input logic [63:0] w, input logic [2:0] off);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++)
            if (i >= int'(off)) r[8*i +: 8] = w[8*(i - int'(off)) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] mask_model(input logic [2:0] off, input logic [1:0] sz);
        logic [7:0] r = '0;
        for (int i = 0; i < (1 << sz); i++)
            if (int'(off) + i < 8) r[int'(off) + i] = 1'b1;
        return r;
    endfunction

    // One clock: check memory port and response handshake, record an accept, then advance.
    task automatic tick();
        exp_t e;
        logic [2:0] off;
        int n;
        #1;
        if (bus.mem_ce) begin
            ce_cnt++;
            chk("mem_addr", bus.mem_addr, p_addr);
            chk("mem_we", 64'(bus.mem_we), 64'(p_we));
            chk("mem_wmask", 64'(bus.mem_wmask), 64'(p_mask));
            chk("mem_wdata", bus.mem_wdata, p_wdata);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", 64'(bus.out_valid), 64'd0);
            else begin
                e = sb.pop_front();
                chk("out_rdata", bus.out_rdata, e.data);
                chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
                chk("out_misalign", 64'(bus.out_misalign), 64'(e.mis));
            end
        end
        took = bus.in_valid && bus.in_ready;
        if (took) begin
            off    = bus.in_addr[2:0];
            n      = 1 << bus.in_size;
            e.rd   = bus.in_rd;
            e.mis  = (int'(off) % n) != 0;
            e.data = (e.mis || bus.in_wen) ? '0 : ld_model(stage_word, off, bus.in_size, bus.in_unsigned);
            if (!e.mis) begin
                mem_word = stage_word;
                p_addr   = {bus.in_addr[63:3], 3'b000};
                p_we     = bus.in_wen;
                p_mask   = bus.in_wen ? mask_model(off, bus.in_size) : 8'h00;
                p_wdata  = wd_model(bus.in_wdata, off);
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] addr, input logic wen, input logic [1:0] sz,
                         input logic uns, input logic [63:0] wd, input logic [4:0] rd,
                         input logic [63:0] word);
        int guard = 0;
        bus.in_addr     = addr;
        bus.in_wen      = wen;
        bus.in_size     = sz;
        bus.in_unsigned = uns;
        bus.in_wdata    = wd;
        bus.in_rd       = rd;
        bus.in_valid    = 1'b1;
        stage_word      = word;
        took            = 1'b0;
        while (!took && guard < 50) begin
            tick();
            guard++;
        end
        if (!took) chk("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        bus.out_ready = 1'b1;
        while (sb.size() > 0 && guard < 30) begin
            tick();
            guard++;
        end
        if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin
        int c0;
        bus.in_valid    = 1'b0;
        bus.in_addr     = '0;
        bus.in_wen      = 1'b0;
        bus.in_size     = '0;
        bus.in_unsigned = 1'b0;
        bus.in_wdata    = '0;
        bus.in_rd       = '0;
        bus.out_ready   = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mem_ce", 64'(bus.mem_ce), 64'd0);
        chk("rst_out_rdata", bus.out_rdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        issue(64'h8000_0003, 1'b1, 2'd0, 1'b0, 64'hAB, 5'd1, 64'h0);
        #1 chk("sb_mask", 64'(bus.mem_wmask), 64'h08);
        chk("sb_wdata", bus.mem_wdata, 64'hAB00_0000);
        drain();

        issue(64'h8000_0006, 1'b0, 2'd1, 1'b0, 64'h0, 5'd2, 64'h8123_0000_0000_0000);
        drain();
        issue(64'h8000_0006, 1'b0, 2'd1, 1'b1, 64'h0, 5'd3, 64'h8123_0000_0000_0000);
        drain();

        c0 = ce_cnt;
        issue(64'h8000_0002, 1'b0, 2'd2, 1'b0, 64'h0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        #1 chk("mis_out_valid", 64'(bus.out_valid), 64'd1);
        chk("mis_flag", 64'(bus.out_misalign), 64'd1);
        chk("mis_mem_ce", 64'(bus.mem_ce), 64'd0);
        drain();
        chk("mis_no_ce", 64'(ce_cnt), 64'(c0));

        bus.out_ready = 1'b0;
        issue(64'h8000_0008, 1'b0, 2'd3, 1'b1, 64'h0, 5'd10, 64'h0123_4567_89AB_CDEF);
        tick();
        c0 = ce_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_rdata", bus.out_rdata, 64'h0123_4567_89AB_CDEF);
            chk("bp_out_rd", 64'(bus.out_rd), 64'd10);
        end
        chk("bp_no_ce", 64'(ce_cnt), 64'(c0));
        bus.out_ready = 1'b1;
        issue(64'h8000_0010, 1'b0, 2'd2, 1'b0, 64'h0, 5'd11, 64'h1111_2222_F333_4444);
        #1 chk("b2b_access", 64'(bus.mem_ce), 64'd1);
        drain();

        issue(64'h8000_0020, 1'b0, 2'd3, 1'b0, 64'h0, 5'd12, 64'h5);
        #1 chk("mid_rst_ce_before", 64'(bus.mem_ce), 64'd1);
        reset_n = 1'b0;
        #1 chk("mid_rst_ce_drop", 64'(bus.mem_ce), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] sz;
            logic [63:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 64'h8000_0000 | 64'($urandom_range(0, 255));
            issue(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
